// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver (and later uart_tx).
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int UART_BAUD_DIV = 434;  // 50 MHz / 115200

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; pointers carry an extra wrap bit.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  // A pop frees the head slot in the same cycle, so a full FIFO may still accept a push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, oversampling state machine and flag registers,
// with received bytes buffered in uart_rx_fifo and drained by valid/ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = UART_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_pin,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   busy_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic                   sync1;
  logic                   rx_s;
  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shift;
  logic                   stop_tick;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [UART_DATA_W-1:0] rdata;

  assign stop_tick = (state == S_STOP) && (cnt == BIT_LAST);
  assign push      = stop_tick && rx_s;
  assign valid_o   = !empty;
  assign pop       = valid_o && ready_i;
  assign data_o    = empty ? '0 : rdata;
  assign busy_o    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rx_s  <= sync1;
    end
  end

  // Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught in time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_tick && !rx_s;
      overrun_o   <= push && full && !pop;
    end
  end

  uart_rx_fifo #(
    .WIDTH(UART_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(shift),
    .pop  (pop),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV=16, FIFO_DEPTH=4: frame table plus hand-written corner sequences,
// with a byte scoreboard checked whenever the DUT hands over data.
module tb_uart_rx;

  localparam int B     = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 2 + B / 2 + 9 * B + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frame_start = 0;
  int last_rise_cyc = 0;
  int valid_cycles = 0;
  int pop_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int busy_cycles = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ferr;
    int         exp_pop;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_DIV  (B),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (rx_pin),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor and scoreboard: every handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) valid_cycles++;
      if (valid_o && !valid_prev) last_rise_cyc = cyc;
      valid_prev = valid_o;
      if (busy_o) busy_cycles++;
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
      if (valid_o && ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no byte", data_o);
        end else begin
          check_output("pop_data", int'(data_o), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic stop);
    frame_start = cyc;
    rx_pin = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      wait_cycles(B);
    end
    rx_pin = stop;
    wait_cycles(B);
    rx_pin = 1'b1;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check_output({tag, "_data"}, int'(data_o), 0);
    check_output({tag, "_valid"}, int'(valid_o), 0);
    check_output({tag, "_ferr"}, int'(frame_err_o), 0);
    check_output({tag, "_ovr"}, int'(overrun_o), 0);
    check_output({tag, "_busy"}, int'(busy_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, f0, o0, v0, b0;

    vecs[0] = '{8'hA5, 1'b1, 0, 1};
    vecs[1] = '{8'h3C, 1'b0, 1, 0};
    vecs[2] = '{8'h81, 1'b1, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 0, 1};
    vecs[4] = '{8'hFF, 1'b1, 0, 1};
    vecs[5] = '{8'hC3, 1'b1, 0, 1};

    wait_cycles(3);
    check_quiet_outputs("reset");
    rst = 1'b1;
    wait_cycles(2 * B);

    // Single frame: exact latency and a one-cycle valid with ready held high
    ready_i = 1'b1;
    v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    apply_stimulus(8'hA5, 1'b1);
    wait_cycles(2 * B);
    check_output("latency", last_rise_cyc - frame_start, LAT);
    check_output("valid_width", valid_cycles - v0, 1);
    check_output("single_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Table of isolated frames, including a bad stop bit followed by a good frame
    foreach (vecs[i]) begin
      p0 = pop_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      if (vecs[i].exp_pop != 0) exp_q.push_back(vecs[i].data);
      apply_stimulus(vecs[i].data, vecs[i].stop);
      wait_cycles(3 * B);
      check_output($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check_output($sformatf("vec%0d_pops", i), pop_cnt - p0, vecs[i].exp_pop);
      check_output($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
      check_output($sformatf("vec%0d_idle", i), int'(busy_o), 0);
    end

    // Back-to-back frames held in the FIFO, then drained on consecutive cycles
    ready_i = 1'b0;
    p0 = pop_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'hFF, 1'b1);
    apply_stimulus(8'h55, 1'b1);
    wait_cycles(2 * B);
    check_output("b2b_valid", int'(valid_o), 1);
    check_output("b2b_head", int'(data_o), 8'h00);
    ready_i = 1'b1;
    wait_cycles(3);
    check_output("b2b_drained", int'(valid_o), 0);
    check_output("b2b_pops", pop_cnt - p0, 3);

    // Short glitch must be rejected as a false start
    p0 = pop_cnt; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cycles;
    rx_pin = 1'b0;
    wait_cycles(6);
    rx_pin = 1'b1;
    wait_cycles(3 * B);
    check_output("glitch_busy_short", int'((busy_cycles - b0) > 0 && (busy_cycles - b0) < 10), 1);
    check_output("glitch_pops", pop_cnt - p0, 0);
    check_output("glitch_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check_output("glitch_idle", int'(busy_o), 0);

    // Overrun: fifth byte dropped with a single pulse, first four intact
    ready_i = 1'b0;
    p0 = pop_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) apply_stimulus(8'(i), 1'b1);
    wait_cycles(2 * B);
    check_output("ovr_pulse", ovr_cnt - o0, 1);
    check_output("ovr_no_ferr", ferr_cnt - f0, 0);
    ready_i = 1'b1;
    wait_cycles(DEPTH);
    ready_i = 1'b0;
    check_output("ovr_drained", int'(valid_o), 0);
    check_output("ovr_pops", pop_cnt - p0, 4);

    // Push into a full FIFO on the same cycle as a pop is accepted
    p0 = pop_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      apply_stimulus(8'h10 + 8'(i), 1'b1);
    end
    wait_cycles(2 * B);
    check_output("full_valid", int'(valid_o), 1);
    exp_q.push_back(8'h14);
    fork
      apply_stimulus(8'h14, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
      end
    join
    wait_cycles(2 * B);
    check_output("full_pop_push_ovr", ovr_cnt - o0, 0);
    check_output("full_pop_one", pop_cnt - p0, 1);
    ready_i = 1'b1;
    wait_cycles(DEPTH);
    check_output("full_drained", int'(valid_o), 0);
    check_output("full_pops", pop_cnt - p0, 5);

    // Reset during data bit 4 clears everything, including a stored byte
    ready_i = 1'b0;
    exp_q.push_back(8'h77);
    apply_stimulus(8'h77, 1'b1);
    wait_cycles(2 * B);
    check_output("pre_reset_valid", int'(valid_o), 1);
    fork
      apply_stimulus(8'h5A, 1'b1);
      begin
        repeat (5 * B + B / 2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        wait_cycles(2);
        check_quiet_outputs("midrst");
      end
    join
    rst = 1'b1;
    wait_cycles(2 * B);
    check_output("post_reset_valid", int'(valid_o), 0);
    check_output("post_reset_busy", int'(busy_o), 0);
    ready_i = 1'b1;
    p0 = pop_cnt;
    exp_q.push_back(8'hC3);
    apply_stimulus(8'hC3, 1'b1);
    wait_cycles(3 * B);
    check_output("post_reset_pop", pop_cnt - p0, 1);

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
